key_extract_cfg_writer: RTL and testbench

Configuration-path writer that produces the key-offset table writes consumed by a stage's key extractor. Sits between the control-packet parser and one pipeline stage. It takes a 32-bit config word stream (valid/ready/last), filters commands by opcode and target stage, and turns each burst into single-cycle writes on `key_off_entry_*`. It also reports per-burst completion and errors, and keeps a running write count.

---
 rtl/cfg_pkg.sv | 35 +++
 rtl/key_extract_cfg_writer.sv | 100 ++++++++++
 tb/tb_key_extract_cfg_writer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_pkg.sv
// Shared definitions for the config-path writers: opcodes, header layout, FSM states.
// Header decode is pure combinational field extraction from the upper half-word.
package cfg_pkg;

  localparam logic [3:0] CFG_OP_KEY_OFF = 4'h1;

  localparam int HDR_OP_LSB    = 28;
  localparam int HDR_STAGE_LSB = 24;
  localparam int HDR_ADDR_LSB  = 20;
  localparam int HDR_LEN_LSB   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } cfg_state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] stage;
    logic [3:0] addr;
    logic [3:0] len_m1;
  } cfg_hdr_t;

  // Bits [15:0] of a header are don't-care, so only the upper half is passed in.
  function automatic cfg_hdr_t cfg_hdr_decode(input logic [31:16] w);
    cfg_hdr_t h;
    h.op     = w[HDR_OP_LSB    +: 4];
    h.stage  = w[HDR_STAGE_LSB +: 4];
    h.addr   = w[HDR_ADDR_LSB  +: 4];
    h.len_m1 = w[HDR_LEN_LSB   +: 4];
    return h;
  endfunction

endpackage

// File: rtl/key_extract_cfg_writer.sv
// Turns key-offset config bursts into single-cycle table writes; writes appear 1 cycle after acceptance.
// Never backpressures: ready is held high from the first clock after reset.
module key_extract_cfg_writer
  import cfg_pkg::*;
#(
  parameter int STAGE              = 0,
  parameter int AXIL_WIDTH         = 32,
  parameter int KEY_OFF            = 18,
  parameter int KEY_OFF_ADDR_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXIL_WIDTH-1:0]         cfg_data_in,
  input  logic                          cfg_valid_in,
  input  logic                          cfg_last_in,
  output logic                          cfg_ready_out,
  output logic [AXIL_WIDTH-1:0]         key_off_entry_out,
  output logic                          key_off_entry_out_valid,
  output logic [KEY_OFF_ADDR_WIDTH-1:0] key_off_entry_addr,
  output logic                          cfg_done,
  output logic                          cfg_err,
  output logic [7:0]                    wr_count
);

  cfg_state_e                    state;
  logic [KEY_OFF_ADDR_WIDTH-1:0] addr_q;
  logic [3:0]                    rem_q;
  logic                          ready_q;
  logic                          acc;
  cfg_hdr_t                      hdr;
  logic                          hdr_key_off;
  logic                          hdr_match;

  assign acc           = cfg_valid_in && ready_q;
  assign hdr           = cfg_hdr_decode(cfg_data_in[31:16]);
  assign hdr_key_off   = (hdr.op == CFG_OP_KEY_OFF);
  assign hdr_match     = (hdr.stage == 4'(STAGE));
  assign cfg_ready_out = ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= ST_IDLE;
      addr_q                  <= '0;
      rem_q                   <= '0;
      ready_q                 <= 1'b0;
      key_off_entry_out       <= '0;
      key_off_entry_out_valid <= 1'b0;
      key_off_entry_addr      <= '0;
      cfg_done                <= 1'b0;
      cfg_err                 <= 1'b0;
      wr_count                <= '0;
    end else begin
      ready_q                 <= 1'b1;
      key_off_entry_out_valid <= 1'b0;
      cfg_done                <= 1'b0;
      cfg_err                 <= 1'b0;
      if (acc) begin
        case (state)
          ST_IDLE: begin
            // A header that is also the last word has no body to drop, so stay in IDLE.
            if (!hdr_key_off) begin
              cfg_err <= 1'b1;
              if (!cfg_last_in) state <= ST_DROP;
            end else if (!hdr_match) begin
              if (!cfg_last_in) state <= ST_DROP;
            end else if (cfg_last_in) begin
              cfg_err <= 1'b1;
            end else begin
              state  <= ST_WRITE;
              addr_q <= KEY_OFF_ADDR_WIDTH'(hdr.addr);
              rem_q  <= hdr.len_m1;
            end
          end
          ST_WRITE: begin
            key_off_entry_out_valid <= 1'b1;
            key_off_entry_out       <= {{(AXIL_WIDTH-KEY_OFF){1'b0}}, cfg_data_in[KEY_OFF-1:0]};
            key_off_entry_addr      <= addr_q;
            addr_q                  <= addr_q + KEY_OFF_ADDR_WIDTH'(1);
            rem_q                   <= rem_q - 4'd1;
            if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
            // rem_q == 0 means this word is the last one the header asked for.
            if (cfg_last_in) begin
              state <= ST_IDLE;
              if (rem_q == 4'd0) cfg_done <= 1'b1;
              else               cfg_err  <= 1'b1;
            end else if (rem_q == 4'd0) begin
              cfg_err <= 1'b1;
              state   <= ST_DROP;
            end
          end
          ST_DROP: begin
            if (cfg_last_in) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_extract_cfg_writer.sv
// Directed bench for key_extract_cfg_writer: per-command reference model plus literal pins.
module tb_key_extract_cfg_writer;

  typedef struct packed {
    logic        vld;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        done;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cfg_data_in;
  logic        cfg_valid_in;
  logic        cfg_last_in;
  logic        cfg_ready_out;
  logic [31:0] key_off_entry_out;
  logic        key_off_entry_out_valid;
  logic [3:0]  key_off_entry_addr;
  logic        cfg_done;
  logic        cfg_err;
  logic [7:0]  wr_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_cnt = 0;
  exp_t        exp_q[$];
  exp_t        log_q[$];
  logic [31:0] dwords[16];

  key_extract_cfg_writer #(
    .STAGE(0), .AXIL_WIDTH(32), .KEY_OFF(18), .KEY_OFF_ADDR_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_data_in(cfg_data_in), .cfg_valid_in(cfg_valid_in), .cfg_last_in(cfg_last_in),
    .cfg_ready_out(cfg_ready_out),
    .key_off_entry_out(key_off_entry_out), .key_off_entry_out_valid(key_off_entry_out_valid),
    .key_off_entry_addr(key_off_entry_addr),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle out of reset: outputs must match the expectation of the word accepted on the previous edge.
  initial begin : compare
    logic acc;
    exp_t e;
    forever begin
      @(posedge clk);
      acc = cfg_valid_in;
      #1;
      if (!rst_n) continue;
      e = '0;
      if (acc) begin
        if (exp_q.size() == 0) chk("exp_queue_underflow", 1, 0);
        else e = exp_q.pop_front();
      end
      if (e.vld && m_cnt < 255) m_cnt++;
      chk("ready", cfg_ready_out, 1);
      chk("strobe", key_off_entry_out_valid, e.vld);
      chk("done", cfg_done, e.done);
      chk("err", cfg_err, e.err);
      chk("wr_count", wr_count, m_cnt);
      if (e.vld) begin
        chk("addr", key_off_entry_addr, e.addr);
        chk("entry", key_off_entry_out, e.data);
      end
      if (key_off_entry_out_valid)
        log_q.push_back('{1'b1, key_off_entry_addr, key_off_entry_out, cfg_done, cfg_err});
    end
  end

  task automatic drive(input logic [31:0] w, input logic l, input exp_t e);
    @(negedge clk);
    cfg_data_in  = w;
    cfg_last_in  = l;
    cfg_valid_in = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    cfg_valid_in = 1'b0;
    cfg_last_in  = 1'b0;
  endtask

  // Header plus dwords[0..n-1]; last rides on the final word unless open is set.
  task automatic run_cmd(input logic [31:0] hdr, input int n, input bit open);
    exp_t e;
    bit   writes;
    bit   is_last;
    int   len;
    int   start;
    e = '0;
    if (hdr[31:28] != 4'h1) e.err = 1'b1;
    else if (hdr[27:24] == 4'h0 && n == 0) e.err = 1'b1;
    drive(hdr, (n == 0) && !open, e);
    writes = (hdr[31:28] == 4'h1) && (hdr[27:24] == 4'h0) && (n > 0);
    len    = int'(hdr[19:16]) + 1;
    start  = int'(hdr[23:20]);
    for (int i = 0; i < n; i++) begin
      e       = '0;
      is_last = (i == n - 1) && !open;
      if (writes && i < len) begin
        e.vld  = 1'b1;
        e.addr = 4'((start + i) % 16);
        e.data = dwords[i] & 32'h0003_FFFF;
        if (is_last && i == len - 1) e.done = 1'b1;
        if (is_last && i < len - 1)  e.err  = 1'b1;
        if (!is_last && i == len - 1) e.err = 1'b1;
      end
      drive(dwords[i], is_last, e);
    end
    if (!open) idle_cycle();
  endtask

  initial begin
    rst_n        = 1'b0;
    cfg_valid_in = 1'b0;
    cfg_last_in  = 1'b0;
    cfg_data_in  = '0;
    #12;
    chk("rst_ready", cfg_ready_out, 0);
    chk("rst_entry", key_off_entry_out, 0);
    chk("rst_strobe", key_off_entry_out_valid, 0);
    chk("rst_addr", key_off_entry_addr, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_wr_count", wr_count, 0);
    @(negedge clk); rst_n = 1'b1;
    idle_cycle(); idle_cycle();

    // Basic 4-entry burst at address 0.
    dwords[0] = 32'h0002_AAAA; dwords[1] = 32'h0001_5555;
    dwords[2] = 32'h0003_FFFF; dwords[3] = 32'h0000_0001;
    log_q.delete();
    run_cmd(32'h1003_0000, 4, 0);
    idle_cycle();
    chk("t1_nwrites", 32'(log_q.size()), 4);
    if (log_q.size() == 4) begin
      chk("t1_e0", log_q[0].data, 32'h0002_AAAA);
      chk("t1_e1", log_q[1].data, 32'h0001_5555);
      chk("t1_e2", log_q[2].data, 32'h0003_FFFF);
      chk("t1_a2", log_q[2].addr, 2);
      chk("t1_e3", log_q[3].data, 32'h0000_0001);
      chk("t1_done3", log_q[3].done, 1);
    end
    chk("t1_wr_count", wr_count, 4);

    // Address wrap 14,15 then 14,15,0.
    dwords[0] = 32'hFFFF_0123; dwords[1] = 32'h0000_0456; dwords[2] = 32'h0001_0789;
    run_cmd(32'h10E1_0000, 2, 0);
    log_q.delete();
    run_cmd(32'h10E2_0000, 3, 0);
    idle_cycle();
    chk("wrap_nwrites", 32'(log_q.size()), 3);
    if (log_q.size() == 3) begin
      chk("wrap_a2", log_q[2].addr, 0);
      chk("wrap_hi_mask", log_q[0].data, 32'h0003_0123);
    end

    // Stage mismatch dropped, then a normal header.
    log_q.delete();
    run_cmd(32'h1100_0000, 3, 0);
    run_cmd(32'h1001_0000, 2, 0);
    idle_cycle();
    chk("mismatch_nwrites", 32'(log_q.size()), 2);

    // Short burst.
    log_q.delete();
    run_cmd(32'h1053_0000, 2, 0);
    idle_cycle();
    chk("short_nwrites", 32'(log_q.size()), 2);
    if (log_q.size() == 2) begin
      chk("short_err", log_q[1].err, 1);
      chk("short_done", log_q[1].done, 0);
    end

    // Long burst, bad opcodes, header-only commands.
    log_q.delete();
    run_cmd(32'h1070_0000, 3, 0);
    idle_cycle();
    chk("long_nwrites", 32'(log_q.size()), 1);
    if (log_q.size() == 1) begin
      chk("long_err", log_q[0].err, 1);
      chk("long_addr", log_q[0].addr, 7);
    end
    run_cmd(32'h7000_0000, 0, 0);
    run_cmd(32'h7000_0000, 2, 0);
    run_cmd(32'h1000_0000, 0, 0);
    run_cmd(32'h1200_0000, 0, 0);

    // Saturation: 17 full 16-entry bursts, back to back.
    for (int b = 0; b < 17; b++) begin
      for (int i = 0; i < 16; i++) dwords[i] = $urandom;
      run_cmd(32'h100F_0000, 16, 0);
    end
    idle_cycle();
    chk("sat_wr_count", wr_count, 255);

    // Reset after 2 of 4 words.
    dwords[0] = 32'h0000_1111; dwords[1] = 32'h0000_2222;
    run_cmd(32'h1003_0000, 2, 1);
    @(negedge clk);
    cfg_valid_in = 1'b0;
    rst_n        = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    #1;
    chk("mid_rst_ready", cfg_ready_out, 0);
    chk("mid_rst_strobe", key_off_entry_out_valid, 0);
    chk("mid_rst_entry", key_off_entry_out, 0);
    chk("mid_rst_addr", key_off_entry_addr, 0);
    chk("mid_rst_wr_count", wr_count, 0);
    idle_cycle(); idle_cycle();
    rst_n = 1'b1;
    idle_cycle(); idle_cycle();
    log_q.delete();
    dwords[0] = 32'h0000_000A; dwords[1] = 32'h0000_000B;
    dwords[2] = 32'h0000_000C; dwords[3] = 32'h0000_000D;
    run_cmd(32'h1023_0000, 4, 0);
    idle_cycle();
    chk("post_rst_nwrites", 32'(log_q.size()), 4);
    if (log_q.size() == 4) begin
      chk("post_rst_a0", log_q[0].addr, 2);
      chk("post_rst_done", log_q[3].done, 1);
    end
    chk("post_rst_wr_count", wr_count, 4);

    idle_cycle(); idle_cycle();
    chk("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
